// File: rtl/fp_stream_pkg.sv
// Shared helpers and constants for the fixed-latency FP core streaming wrapper.
package fp_stream_pkg;

  localparam logic CORE_CLK_EN = 1'b1;

  function automatic int lanes_w(input int lanes, input int data_w);
    return lanes * data_w;
  endfunction

endpackage

// File: rtl/fp_stream_fifo.sv
// Synchronous show-ahead FIFO; head entry is visible on rd_data whenever !empty.
module fp_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Extra pointer MSB separates the full and empty cases when the indices match.
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fp_stream_wrap.sv
// Credit-based valid/ready wrapper around a free-running fixed-latency FP core;
// results land in an output FIFO whose space was reserved when the beat was accepted.
module fp_stream_wrap
  import fp_stream_pkg::*;
#(
  parameter int LATENCY    = 17,
  parameter int DATA_W     = 32,
  parameter int LANES      = 1,
  parameter int USER_W     = 2,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    snk_valid,
  output logic                                    snk_ready,
  input  logic [lanes_w(LANES, DATA_W)-1:0]       snk_data,
  input  logic [USER_W-1:0]                       snk_user,
  output logic                                    core_clk_en,
  output logic [lanes_w(LANES, DATA_W)-1:0]       core_data_in,
  input  logic [lanes_w(LANES, DATA_W)-1:0]       core_data_out,
  output logic                                    src_valid,
  input  logic                                    src_ready,
  output logic [lanes_w(LANES, DATA_W)-1:0]       src_data,
  output logic [USER_W-1:0]                       src_user,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]         used
);

  localparam int LW = lanes_w(LANES, DATA_W);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [LW-1:0]     data;
    logic [USER_W-1:0] user;
  } entry_t;

  logic [CW-1:0]      used_q;
  logic [CW-1:0]      used_d;
  logic [LATENCY-1:0] vld_q;
  logic [USER_W-1:0]  usr_q [LATENCY];
  logic               accept;
  logic               pop;
  logic               fifo_empty;
  logic               fifo_full;
  entry_t             wr_entry;
  entry_t             rd_entry;

  assign core_clk_en  = CORE_CLK_EN;
  assign core_data_in = snk_data;

  assign snk_ready = (used_q < CW'(FIFO_DEPTH));
  assign accept    = snk_valid && snk_ready;
  assign src_valid = !fifo_empty;
  assign pop       = src_valid && src_ready;
  assign used      = used_q;
  assign src_data  = rd_entry.data;
  assign src_user  = rd_entry.user;

  always_comb begin
    used_d = used_q;
    if (accept && !pop)      used_d = used_q + CW'(1);
    else if (pop && !accept) used_d = used_q - CW'(1);
  end

  // Clearing the valid line is what makes stale core results harmless after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      used_q <= '0;
      vld_q  <= '0;
    end else begin
      used_q   <= used_d;
      vld_q[0] <= accept;
      for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    usr_q[0] <= snk_user;
    for (int i = 1; i < LATENCY; i++) usr_q[i] <= usr_q[i-1];
  end

  assign wr_entry = '{data: core_data_out, user: usr_q[LATENCY-1]};

  fp_stream_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (vld_q[LATENCY-1] && !fifo_full),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (rd_entry),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

endmodule

// File: tb/tb_fp_stream_wrap.sv
// Scoreboard bench for fp_stream_wrap with an identity core of LATENCY cycles.
module tb_fp_stream_wrap;

  localparam int LAT   = 17;
  localparam int DW    = 32;
  localparam int LN    = 2;
  localparam int UW    = 2;
  localparam int DEPTH = 32;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int LW    = LN * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          snk_valid;
  logic          snk_ready;
  logic [LW-1:0] snk_data;
  logic [UW-1:0] snk_user;
  logic          core_clk_en;
  logic [LW-1:0] core_data_in;
  logic [LW-1:0] core_data_out;
  logic          src_valid;
  logic          src_ready;
  logic [LW-1:0] src_data;
  logic [UW-1:0] src_user;
  logic [CW-1:0] used;

  always #5 clk = ~clk;

  fp_stream_wrap #(
    .LATENCY(LAT), .DATA_W(DW), .LANES(LN), .USER_W(UW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_data(snk_data), .snk_user(snk_user),
    .core_clk_en(core_clk_en), .core_data_in(core_data_in), .core_data_out(core_data_out),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data), .src_user(src_user),
    .used(used)
  );

  // Identity core: output in cycle t+LAT equals input presented in cycle t.
  logic [LW-1:0] core_pipe [LAT];
  always @(posedge clk) begin
    core_pipe[0] <= core_data_in;
    for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_data_out = core_pipe[LAT-1];

  typedef struct {
    logic [LW-1:0] d;
    logic [UW-1:0] u;
    int            rdy;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            used_m = 0;
  int            acc_total = 0;
  logic          held_v = 1'b0;
  logic [LW-1:0] held_d;
  logic [UW-1:0] held_u;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, handshakes are those about to complete.
  always @(negedge clk) begin
    exp_t e;
    logic exp_v;
    int   d_used;
    if (rst) begin
      sb.delete();
      used_m = 0;
      held_v = 1'b0;
    end else begin
      chk("used", used, used_m);
      chk("snk_ready", snk_ready, used_m < DEPTH);
      chk("core_clk_en", core_clk_en, 1'b1);
      exp_v = (sb.size() > 0) && (sb[0].rdy <= cyc);
      chk("src_valid", src_valid, exp_v);
      if (held_v && src_valid) begin
        chk("stall_data", src_data, held_d);
        chk("stall_user", src_user, held_u);
      end
      held_v = src_valid && !src_ready;
      held_d = src_data;
      held_u = src_user;
      d_used = 0;
      if (src_valid && src_ready) begin
        d_used--;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL pop_unexpected: got data %0h with no beat outstanding", src_data);
        end else begin
          e = sb.pop_front();
          chk("src_data", src_data, e.d);
          chk("src_user", src_user, e.u);
        end
      end
      if (snk_valid && snk_ready) begin
        d_used++;
        acc_total++;
        sb.push_back('{snk_data, snk_user, cyc + LAT + 1});
      end
      used_m = used_m + d_used;
    end
  end

  task automatic drive(input logic v, input logic r);
    @(posedge clk);
    #1;
    snk_valid = v;
    src_ready = r;
    snk_data  = {$urandom, $urandom};
    snk_user  = UW'($urandom);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) drive(1'b0, r);
  endtask

  initial begin
    int t0;
    int found;
    int cnt;
    int guard;
    rst       = 1'b1;
    snk_valid = 1'b0;
    src_ready = 1'b0;
    snk_data  = '0;
    snk_user  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_src_valid", src_valid, 1'b0);
    chk("rst_used", used, 0);
    chk("rst_snk_ready", snk_ready, 1'b1);

    // Single beat, latency measurement
    @(posedge clk);
    #1;
    snk_valid = 1'b1;
    src_ready = 1'b1;
    snk_data  = 64'h3F800000_40000000;
    snk_user  = 2'b01;
    t0 = cyc;
    drive(1'b0, 1'b1);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (src_valid) begin
        found = 1;
        break;
      end
    end
    if (found == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL single_timeout: src_valid never rose within 40 cycles");
    end else begin
      chk("single_latency", cyc - t0, LAT + 1);
      chk("single_data", src_data, 64'h3F800000_40000000);
      chk("single_user", src_user, 2'b01);
    end
    idle(3, 1'b1);

    // 100-beat burst with free-flowing output
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 1'b1);
      @(negedge clk);
      chk("burst_ready", snk_ready, 1'b1);
    end
    idle(40, 1'b1);

    // Fill with output stalled
    cnt = 0;
    for (int i = 0; i < 45; i++) begin
      drive(1'b1, 1'b0);
      @(negedge clk);
      if (snk_valid && snk_ready) cnt++;
    end
    chk("fill_count", cnt, DEPTH);
    chk("fill_used", used, DEPTH);
    chk("fill_ready", snk_ready, 1'b0);

    // One pop down to DEPTH-1, then simultaneous accept and pop
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    @(negedge clk);
    chk("minus1_used", used, DEPTH - 1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    @(negedge clk);
    chk("acc_pop_used", used, DEPTH - 1);
    chk("acc_pop_ready", snk_ready, 1'b1);
    for (int i = 0; i < 60; i++) drive(1'b1, 1'b1);
    idle(60, 1'b1);

    // Reset with 5 buffered and 10 in flight
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0);
    idle(20, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0);
    @(posedge clk);
    #1;
    snk_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    src_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_src_valid", src_valid, 1'b0);
    chk("mid_rst_used", used, 0);
    chk("mid_rst_ready", snk_ready, 1'b1);
    idle(40, 1'b1);

    // Randomised traffic
    cnt   = acc_total;
    guard = 0;
    while ((acc_total - cnt) < 10000 && guard < 60000) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      guard++;
    end
    if (guard >= 60000) begin
      n_cmp++;
      n_err++;
      $display("FAIL random_timeout: only %0d beats accepted", acc_total - cnt);
    end
    guard = 0;
    drive(1'b0, 1'b1);
    while (sb.size() > 0 && guard < 200) begin
      drive(1'b0, 1'b1);
      guard++;
    end
    idle(2, 1'b1);
    @(negedge clk);
    chk("drain_empty", sb.size(), 0);
    chk("drain_used", used, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
